// File: rtl/reservation_station.sv
// Reservation station: RS_DEPTH entries, CDB operand wakeup, lowest-index allocate and issue.
// Optional macro RS_CDB_BYPASS_EN: a CDB-woken entry issues in the broadcast cycle with cdb_value forwarded.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module rs_entry #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush_i,
  input  logic         alloc_i,
  input  logic         free_i,
  input  logic [3:0]   d_op_i,
  input  logic [W-1:0] d_dest_i,
  input  logic [31:0]  d_a_val_i,
  input  logic [W-1:0] d_a_tag_i,
  input  logic [31:0]  d_b_val_i,
  input  logic [W-1:0] d_b_tag_i,
  input  logic         cdb_valid_i,
  input  logic [W-1:0] cdb_idx_i,
  input  logic [31:0]  cdb_val_i,
  output logic         vld_o,
  output logic         rdy_o,
  output logic [3:0]   op_o,
  output logic [W-1:0] dest_o,
  output logic [31:0]  a_o,
  output logic [31:0]  b_o
);
  logic         vld_q, vld_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] dest_q, dest_d;
  logic [31:0]  a_val_q, a_val_d, b_val_q, b_val_d;
  logic [W-1:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic         cdb_live, a_hit, b_hit, da_hit, db_hit;

  // Tag 0 means "value present", so a broadcast on index 0 never matches.
  assign cdb_live = cdb_valid_i && (cdb_idx_i != '0);
  assign a_hit    = cdb_live && vld_q && (a_tag_q == cdb_idx_i);
  assign b_hit    = cdb_live && vld_q && (b_tag_q == cdb_idx_i);
  assign da_hit   = cdb_live && (d_a_tag_i == cdb_idx_i);
  assign db_hit   = cdb_live && (d_b_tag_i == cdb_idx_i);

  always_comb begin
    vld_d   = vld_q;
    op_d    = op_q;
    dest_d  = dest_q;
    a_val_d = a_val_q;
    a_tag_d = a_tag_q;
    b_val_d = b_val_q;
    b_tag_d = b_tag_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (alloc_i) begin
      vld_d   = 1'b1;
      op_d    = d_op_i;
      dest_d  = d_dest_i;
      a_val_d = da_hit ? cdb_val_i : d_a_val_i;
      a_tag_d = da_hit ? '0 : d_a_tag_i;
      b_val_d = db_hit ? cdb_val_i : d_b_val_i;
      b_tag_d = db_hit ? '0 : d_b_tag_i;
    end else if (free_i) begin
      vld_d = 1'b0;
    end else begin
      if (a_hit) begin
        a_val_d = cdb_val_i;
        a_tag_d = '0;
      end
      if (b_hit) begin
        b_val_d = cdb_val_i;
        b_tag_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q   <= 1'b0;
      op_q    <= '0;
      dest_q  <= '0;
      a_val_q <= '0;
      a_tag_q <= '0;
      b_val_q <= '0;
      b_tag_q <= '0;
    end else begin
      vld_q   <= vld_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      a_val_q <= a_val_d;
      a_tag_q <= a_tag_d;
      b_val_q <= b_val_d;
      b_tag_q <= b_tag_d;
    end
  end

  assign vld_o  = vld_q;
  assign op_o   = op_q;
  assign dest_o = dest_q;
`ifdef RS_CDB_BYPASS_EN
  assign rdy_o = vld_q && ((a_tag_q == '0) || a_hit) && ((b_tag_q == '0) || b_hit);
  assign a_o   = a_hit ? cdb_val_i : a_val_q;
  assign b_o   = b_hit ? cdb_val_i : b_val_q;
`else
  assign rdy_o = vld_q && (a_tag_q == '0) && (b_tag_q == '0);
  assign a_o   = a_val_q;
  assign b_o   = b_val_q;
`endif
endmodule

module reservation_station #(
  parameter int RS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [3:0]                  disp_op,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_rob_dest,
  input  logic [31:0]                 disp_opA_value,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_opA_tag,
  input  logic [31:0]                 disp_opB_value,
  input  logic [`ROB_ENTRY_WIDTH-1:0] disp_opB_tag,
  input  logic                        cdb_valid,
  input  logic [`ROB_ENTRY_WIDTH-1:0] cdb_rob_index,
  input  logic [31:0]                 cdb_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [3:0]                  issue_op,
  output logic [31:0]                 issue_opA,
  output logic [31:0]                 issue_opB,
  output logic [`ROB_ENTRY_WIDTH-1:0] issue_rob_dest,
  output logic [3:0]                  rs_count
);
  localparam int W = `ROB_ENTRY_WIDTH;

  logic [RS_DEPTH-1:0]         vld, rdy, alloc_oh, sel_oh;
  logic [RS_DEPTH-1:0][3:0]    ent_op;
  logic [RS_DEPTH-1:0][W-1:0]  ent_dest;
  logic [RS_DEPTH-1:0][31:0]   ent_a, ent_b;
  logic                        disp_fire, issue_fire;

  // Lowest clear bit of vld / lowest set bit of rdy, as one-hot vectors.
  assign alloc_oh   = ~vld & (vld + RS_DEPTH'(1));
  assign sel_oh     = rdy & (~rdy + RS_DEPTH'(1));
  assign disp_ready = ~&vld;
  assign issue_valid = |rdy;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready && !flush;

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ent
    rs_entry #(.W(W)) u_ent (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (flush),
      .alloc_i     (disp_fire && alloc_oh[i]),
      .free_i      (issue_fire && sel_oh[i]),
      .d_op_i      (disp_op),
      .d_dest_i    (disp_rob_dest),
      .d_a_val_i   (disp_opA_value),
      .d_a_tag_i   (disp_opA_tag),
      .d_b_val_i   (disp_opB_value),
      .d_b_tag_i   (disp_opB_tag),
      .cdb_valid_i (cdb_valid),
      .cdb_idx_i   (cdb_rob_index),
      .cdb_val_i   (cdb_value),
      .vld_o       (vld[i]),
      .rdy_o       (rdy[i]),
      .op_o        (ent_op[i]),
      .dest_o      (ent_dest[i]),
      .a_o         (ent_a[i]),
      .b_o         (ent_b[i])
    );
  end

  always_comb begin
    issue_op       = '0;
    issue_opA      = '0;
    issue_opB      = '0;
    issue_rob_dest = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel_oh[i]) begin
        issue_op       = ent_op[i];
        issue_opA      = ent_a[i];
        issue_opB      = ent_b[i];
        issue_rob_dest = ent_dest[i];
      end
    end
  end

  always_comb begin
    rs_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) rs_count = rs_count + 4'(vld[i]);
  end
endmodule

// File: tb/tb_reservation_station.sv
// Randomized and directed bench for reservation_station against a slot-array reference model.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module tb_reservation_station;
  localparam int W  = `ROB_ENTRY_WIDTH;
  localparam int D  = 4;
  localparam int OW = 2 + 4 + 64 + W + 4;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic         disp_valid = 1'b0, disp_ready;
  logic [3:0]   disp_op = '0;
  logic [W-1:0] disp_rob_dest = '0, disp_opA_tag = '0, disp_opB_tag = '0;
  logic [31:0]  disp_opA_value = '0, disp_opB_value = '0;
  logic         cdb_valid = 1'b0;
  logic [W-1:0] cdb_rob_index = '0;
  logic [31:0]  cdb_value = '0;
  logic         issue_valid, issue_ready = 1'b0;
  logic [3:0]   issue_op, rs_count;
  logic [31:0]  issue_opA, issue_opB;
  logic [W-1:0] issue_rob_dest;

  reservation_station #(.RS_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_rob_dest(disp_rob_dest), .disp_opA_value(disp_opA_value), .disp_opA_tag(disp_opA_tag),
    .disp_opB_value(disp_opB_value), .disp_opB_tag(disp_opB_tag),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rob_dest(issue_rob_dest),
    .rs_count(rs_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dv; logic [3:0] op; logic [W-1:0] dest;
    logic [31:0] av; logic [W-1:0] at; logic [31:0] bv; logic [W-1:0] bt;
    logic cv; logic [W-1:0] ci; logic [31:0] cval; logic ir; logic fl;
  } vec_t;

  typedef struct packed {
    logic v; logic [3:0] op; logic [W-1:0] dest;
    logic [31:0] av; logic [W-1:0] at; logic [31:0] bv; logic [W-1:0] bt;
  } ent_t;

  ent_t        m[D], mn[D];
  logic [OW-1:0] obs, exp_v;
  int          nvec = 0, nerr = 0;

  assign obs = {disp_ready, issue_valid, issue_op, issue_opA, issue_opB, issue_rob_dest, rs_count};

  function automatic vec_t V(logic dv, logic [3:0] op, logic [W-1:0] dest, logic [31:0] av,
                             logic [W-1:0] at, logic [31:0] bv, logic [W-1:0] bt, logic cv,
                             logic [W-1:0] ci, logic [31:0] cval, logic ir, logic fl);
    return {dv, op, dest, av, at, bv, bt, cv, ci, cval, ir, fl};
  endfunction

  function automatic logic hit(logic [W-1:0] t);
    return cdb_valid && (t != '0) && (t == cdb_rob_index);
  endfunction

  // Operand considered available: present, or (with bypass) being broadcast now.
  function automatic logic avail(logic [W-1:0] t);
    return (t == '0) || (BYP && hit(t));
  endfunction

  task automatic drive(input vec_t v);
    disp_valid = v.dv; disp_op = v.op; disp_rob_dest = v.dest;
    disp_opA_value = v.av; disp_opA_tag = v.at; disp_opB_value = v.bv; disp_opB_tag = v.bt;
    cdb_valid = v.cv; cdb_rob_index = v.ci; cdb_value = v.cval;
    issue_ready = v.ir; flush = v.fl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) m[i] = '0;
  endtask

  // Expected outputs for current inputs, and state after the coming edge.
  task automatic model_eval();
    int sel, fr, cnt;
    logic [31:0] ea, eb;
    sel = -1; fr = -1; cnt = 0; ea = '0; eb = '0;
    for (int i = 0; i < D; i++) begin
      if (m[i].v) cnt++;
      else if (fr < 0) fr = i;
      if (m[i].v && sel < 0 && avail(m[i].at) && avail(m[i].bt)) sel = i;
    end
    if (sel >= 0) begin
      ea = (BYP && hit(m[sel].at)) ? cdb_value : m[sel].av;
      eb = (BYP && hit(m[sel].bt)) ? cdb_value : m[sel].bv;
      exp_v = {fr >= 0, 1'b1, m[sel].op, ea, eb, m[sel].dest, 4'(cnt)};
    end else begin
      exp_v = {fr >= 0, 1'b0, 4'd0, 32'd0, 32'd0, {W{1'b0}}, 4'(cnt)};
    end
    mn = m;
    if (flush) begin
      for (int i = 0; i < D; i++) mn[i].v = 1'b0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (mn[i].v && hit(mn[i].at)) begin mn[i].av = cdb_value; mn[i].at = '0; end
        if (mn[i].v && hit(mn[i].bt)) begin mn[i].bv = cdb_value; mn[i].bt = '0; end
      end
      if (sel >= 0 && issue_ready) mn[sel].v = 1'b0;
      if (disp_valid && fr >= 0) begin
        mn[fr].v = 1'b1; mn[fr].op = disp_op; mn[fr].dest = disp_rob_dest;
        mn[fr].av = hit(disp_opA_tag) ? cdb_value : disp_opA_value;
        mn[fr].at = hit(disp_opA_tag) ? '0 : disp_opA_tag;
        mn[fr].bv = hit(disp_opB_tag) ? cdb_value : disp_opB_value;
        mn[fr].bt = hit(disp_opB_tag) ? '0 : disp_opB_tag;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m = mn;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t idle;
    idle = '0;
    drive(idle);
    model_clear();
    @(negedge clk);
    #1;
    if (obs !== {1'b1, 1'b0, 4'd0, 32'd0, 32'd0, {W{1'b0}}, 4'd0}) begin
      $display("FAIL reset_outputs got %h want reset values", obs); nerr++;
    end
    nvec++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    vec_t t[3];
    t[0] = V(1, 4'd2, 4'd1, 32'd5, 0, 32'd7, 0, 0, 0, 0, 1, 0);
    t[1] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t[2] = t[1];
    for (int k = 0; k < 3; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL basic[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == 1 && {issue_valid, issue_op, issue_opA, issue_opB, rs_count} !== {1'b1, 4'd2, 32'd5, 32'd7, 4'd1}) begin
        $display("FAIL basic_issue got v=%0b op=%0d A=%0d B=%0d cnt=%0d want 1/2/5/7/1",
                 issue_valid, issue_op, issue_opA, issue_opB, rs_count); nerr++;
      end
      if (k == 2 && rs_count !== 4'd0) begin
        $display("FAIL basic_drain got cnt=%0d want 0", rs_count); nerr++;
      end
      tick();
    end
  endtask

  task automatic test_cdb_wakeup();
    vec_t t[4];
    t[0] = V(1, 4'd3, 4'd5, 32'd1, 0, 32'd0, 4'd3, 0, 0, 0, 1, 0);
    t[1] = V(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'h1234, 1, 0);
    t[2] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t[3] = t[2];
    for (int k = 0; k < 4; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL cdb_wakeup[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == (BYP ? 1 : 2) && {issue_valid, issue_opB, issue_rob_dest} !== {1'b1, 32'h1234, 4'd5}) begin
        $display("FAIL cdb_issue[%0d] got v=%0b B=%h dest=%0d want 1/1234/5", k, issue_valid, issue_opB, issue_rob_dest);
        nerr++;
      end
      tick();
    end
  endtask

  task automatic test_dispatch_wakeup();
    vec_t t[4];
    t[0] = V(1, 4'd4, 4'd6, 32'd0, 4'd2, 32'd4, 0, 1, 4'd2, 32'd9, 0, 0);
    t[1] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t[2] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t[3] = t[1];
    for (int k = 0; k < 4; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL disp_wakeup[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == 1 && {issue_valid, issue_opA, issue_opB} !== {1'b1, 32'd9, 32'd4}) begin
        $display("FAIL disp_wakeup_val got v=%0b A=%0d B=%0d want 1/9/4", issue_valid, issue_opA, issue_opB); nerr++;
      end
      tick();
    end
  endtask

  task automatic test_full();
    vec_t t[10];
    for (int k = 0; k < 5; k++) t[k] = V(1, 4'(k), 4'(k + 1), 32'(10 + k), 0, 32'(20 + k), 0, 0, 0, 0, 0, 0);
    t[5] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t[6] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 7; k < 10; k++) t[k] = t[5];
    for (int k = 0; k < 10; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL full[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == 4 && {disp_ready, rs_count} !== {1'b0, 4'd4}) begin
        $display("FAIL full_stall got rdy=%0b cnt=%0d want 0/4", disp_ready, rs_count); nerr++;
      end
      if (k == 6 && {disp_ready, rs_count} !== {1'b1, 4'd3}) begin
        $display("FAIL full_release got rdy=%0b cnt=%0d want 1/3", disp_ready, rs_count); nerr++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    vec_t t[5];
    for (int k = 0; k < 3; k++) t[k] = V(1, 4'd1, 4'(k + 1), 32'd1, 4'd6, 32'd2, 0, 0, 0, 0, 0, 0);
    t[3] = V(1, 4'd7, 4'd9, 32'd3, 0, 32'd3, 0, 1, 4'd6, 32'd5, 1, 1);
    t[4] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL flush[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == 4 && {rs_count, issue_valid, disp_ready} !== {4'd0, 1'b0, 1'b1}) begin
        $display("FAIL flush_empty got cnt=%0d iv=%0b rdy=%0b want 0/0/1", rs_count, issue_valid, disp_ready); nerr++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    vec_t t[4];
    t[0] = V(1, 4'd5, 4'd2, 32'd8, 4'd7, 32'd8, 0, 0, 0, 0, 0, 0);
    t[1] = V(1, 4'd6, 4'd3, 32'd8, 0, 32'd9, 0, 0, 0, 0, 0, 0);
    t[2] = V(1, 4'd8, 4'd4, 32'h55, 0, 32'h66, 0, 0, 0, 0, 0, 0);
    t[3] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL reset_mid[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      tick();
    end
    drive(t[3]);
    #2 rstn = 1'b0;
    #1;
    if (obs !== {1'b1, 1'b0, 4'd0, 32'd0, 32'd0, {W{1'b0}}, 4'd0}) begin
      $display("FAIL reset_async got %h want reset values", obs); nerr++;
    end
    nvec++;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 2; k < 4; k++) begin
      drive(t[k]); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL after_reset[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      if (k == 3 && {issue_valid, issue_op, issue_opA, rs_count} !== {1'b1, 4'd8, 32'h55, 4'd1}) begin
        $display("FAIL after_reset_issue got v=%0b op=%0d A=%h cnt=%0d want 1/8/55/1",
                 issue_valid, issue_op, issue_opA, rs_count); nerr++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    vec_t v;
    for (int k = 0; k < 600; k++) begin
      v.dv   = ($urandom_range(0, 9) < 6);
      v.op   = 4'($urandom);
      v.dest = W'($urandom);
      v.av   = $urandom;
      v.at   = $urandom_range(0, 1) ? W'($urandom_range(1, 7)) : '0;
      v.bv   = $urandom;
      v.bt   = $urandom_range(0, 1) ? W'($urandom_range(1, 7)) : '0;
      v.cv   = $urandom_range(0, 1);
      v.ci   = W'($urandom_range(0, 7));
      v.cval = $urandom;
      v.ir   = ($urandom_range(0, 9) < 6);
      v.fl   = ($urandom_range(0, 49) == 0);
      drive(v); #1; model_eval();
      if (obs !== exp_v) begin $display("FAIL random[%0d] got %h want %h", k, obs, exp_v); nerr++; end
      nvec++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_dispatch_wakeup();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
